// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
interface if_prefetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [15:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// Prefetching IF stage: credit-limited in-order imem fetches, a small queue,
// and the IF/ID register with stall, redirect flush and nop bubbles.
module if_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clock,
  input  logic                reset,
  if_prefetch_unit_if.master  mem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [15:0]         redirect_target,
  output logic                ifid_valid,
  output logic [15:0]         ifid_ir,
  output logic [15:0]         ifid_pc,
  output logic [15:0]         ifid_pcplus2
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]   DEPTH_CREDIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_COUNT  = CW'(DEPTH);

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic          ifid_valid_q, ifid_valid_d;
  logic [15:0]   ifid_ir_q, ifid_ir_d;
  logic [15:0]   ifid_pc_q, ifid_pc_d;
  logic [15:0]   ifid_pc2_q, ifid_pc2_d;

  logic [15:0]   qdata_q [DEPTH];
  logic [15:0]   qpc_q   [DEPTH];

  logic [CW:0]   used;
  logic          req_valid, fire, resp, keep, pop;
  logic [15:0]   target_pc;

  assign target_pc = {redirect_target[15:1], 1'b0};
  // Discarded in-flight fetches still hold credit until their words return.
  assign used      = {1'b0, count_q} + {1'b0, out_q};
  assign req_valid = !reset && !redirect && (used < DEPTH_CREDIT);
  assign fire      = req_valid && mem.imem_req_ready;
  assign resp      = mem.imem_resp_valid;
  assign keep      = resp && (disc_q == '0) && !redirect;
  assign pop       = !redirect && !stall && (count_q != '0);

  assign mem.imem_req_valid = req_valid;
  assign mem.imem_req_addr  = fetch_pc_q;

  assign ifid_valid   = ifid_valid_q;
  assign ifid_ir      = ifid_ir_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_pcplus2 = ifid_pc2_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    count_d      = count_q;
    out_d        = out_q + CW'(fire) - CW'(resp);
    disc_d       = disc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    ifid_valid_d = ifid_valid_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc2_d   = ifid_pc2_q;

    if (redirect) begin
      // A word returning in the redirect cycle is already stale, hence the minus.
      fetch_pc_d   = target_pc;
      resp_pc_d    = target_pc;
      count_d      = '0;
      head_d       = '0;
      tail_d       = '0;
      disc_d       = out_q - CW'(resp);
      ifid_valid_d = 1'b0;
      ifid_ir_d    = '0;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + 16'd2;
      if (resp && (disc_q != '0)) disc_d = disc_q - CW'(1);
      if (keep) begin
        tail_d    = tail_q + AW'(1);
        resp_pc_d = resp_pc_q + 16'd2;
      end
      if (!stall) begin
        if (count_q != '0) begin
          ifid_valid_d = 1'b1;
          ifid_ir_d    = qdata_q[head_q];
          ifid_pc_d    = qpc_q[head_q];
          ifid_pc2_d   = qpc_q[head_q] + 16'd2;
          head_d       = head_q + AW'(1);
        end else begin
          ifid_valid_d = 1'b0;
          ifid_ir_d    = '0;
        end
      end
      count_d = count_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      count_q      <= '0;
      out_q        <= '0;
      disc_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_ir_q    <= '0;
      ifid_pc_q    <= '0;
      ifid_pc2_q   <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      count_q      <= count_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc2_q   <= ifid_pc2_d;
    end
  end

  always_ff @(negedge clock) begin
    if (keep) begin
      qdata_q[tail_q] <= mem.imem_resp_data;
      qpc_q[tail_q]   <= resp_pc_q;
    end
  end

  a_no_overflow: assert property (@(negedge clock) disable iff (reset)
    !(keep && (count_q == DEPTH_COUNT)));
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit: an in-order memory model with random
// latency feeds the DUT, and a queue-based fetch model predicts every output.
module tb_if_prefetch_unit;
  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        ifid_valid;
  logic [15:0] ifid_ir;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pcplus2;

  if_prefetch_unit_if mem_if ();

  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clock           (clock),
    .reset           (reset),
    .mem             (mem_if),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_ir         (ifid_ir),
    .ifid_pc         (ifid_pc),
    .ifid_pcplus2    (ifid_pcplus2)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [15:0] addr; logic stale; } fetch_t;
  typedef struct packed { logic [15:0] data; logic [15:0] pc; } entry_t;

  fetch_t      inflight[$];
  entry_t      pq[$];
  logic [15:0] mq[$];
  logic [15:0] m_fetch_pc;
  logic        m_valid;
  logic [15:0] m_ir, m_pc, m_pc2;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    t = (a >> 1) + 16'd1;
    return t * 16'h1111;
  endfunction

  task automatic model_reset();
    inflight.delete();
    pq.delete();
    mq.delete();
    m_fetch_pc = 16'h0000;
    m_valid    = 1'b0;
    m_ir       = '0;
    m_pc       = '0;
    m_pc2      = '0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    reset = 1'b1;
    mem_if.imem_req_ready  = 1'b0;
    mem_if.imem_resp_valid = 1'b0;
    mem_if.imem_resp_data  = '0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    model_reset();
    #1;
    check("rst_req_valid", {15'b0, mem_if.imem_req_valid}, 16'h0000);
    check("rst_valid", {15'b0, ifid_valid}, 16'h0000);
    check("rst_ir", ifid_ir, 16'h0000);
    check("rst_pc", ifid_pc, 16'h0000);
    check("rst_pc2", ifid_pcplus2, 16'h0000);
    @(posedge clock);
    reset = 1'b0;
  endtask

  // One clock: check registered outputs, drive inputs, check request, advance model.
  task automatic step(input bit rdy, input bit rsp_en, input bit stl, input bit rdr,
                      input logic [15:0] tgt);
    logic        ev, rv;
    logic [15:0] rd;
    fetch_t      f;
    entry_t      e;
    @(posedge clock);
    check("ifid_valid", {15'b0, ifid_valid}, {15'b0, m_valid});
    check("ifid_ir", ifid_ir, m_ir);
    check("ifid_pc", ifid_pc, m_pc);
    check("ifid_pcplus2", ifid_pcplus2, m_pc2);

    rv = rsp_en && (mq.size() > 0);
    rd = rv ? mem_word(mq[0]) : 16'($urandom);
    mem_if.imem_req_ready  = rdy;
    mem_if.imem_resp_valid = rv;
    mem_if.imem_resp_data  = rd;
    stall           = stl;
    redirect        = rdr;
    redirect_target = tgt;
    ev = !rdr && ((pq.size() + inflight.size()) < DEPTH);
    #1;
    check("req_valid", {15'b0, mem_if.imem_req_valid}, {15'b0, ev});
    if (ev) check("req_addr", mem_if.imem_req_addr, m_fetch_pc);

    if (rv) void'(mq.pop_front());
    if (mem_if.imem_req_valid && rdy) mq.push_back(mem_if.imem_req_addr);

    f = '{addr: 16'h0000, stale: 1'b1};
    if (rv && inflight.size() > 0) f = inflight.pop_front();
    if (rdr) begin
      for (int i = 0; i < inflight.size(); i++) inflight[i].stale = 1'b1;
      pq.delete();
      m_valid    = 1'b0;
      m_ir       = '0;
      m_fetch_pc = tgt & 16'hFFFE;
    end else begin
      if (!stl) begin
        if (pq.size() > 0) begin
          e = pq.pop_front();
          m_valid = 1'b1;
          m_ir    = e.data;
          m_pc    = e.pc;
          m_pc2   = e.pc + 16'd2;
        end else begin
          m_valid = 1'b0;
          m_ir    = '0;
        end
      end
      if (rv && !f.stale) pq.push_back('{data: rd, pc: f.addr});
      if (ev && rdy) begin
        inflight.push_back('{addr: m_fetch_pc, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 16'd2;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    do_reset();

    // zero-wait memory from reset
    repeat (3) step(1, 1, 0, 0, 16'h0);
    @(negedge clock); #1;
    check("zw_first_ir", ifid_ir, 16'h1111);
    check("zw_first_pc", ifid_pc, 16'h0000);
    check("zw_first_pc2", ifid_pcplus2, 16'h0002);
    repeat (6) step(1, 1, 0, 0, 16'h0);

    // memory not ready for 3 cycles after reset
    do_reset();
    repeat (3) step(0, 1, 0, 0, 16'h0);
    repeat (6) step(1, 1, 0, 0, 16'h0);

    // stall with the queue filling, then release
    repeat (5) step(1, 1, 1, 0, 16'h0);
    repeat (6) step(1, 1, 0, 0, 16'h0);

    // redirect with two fetches in flight
    do_reset();
    repeat (2) step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, 16'h0041);
    @(negedge clock); #1;
    check("rd_next_addr", mem_if.imem_req_addr, 16'h0040);
    repeat (8) step(1, 1, 0, 0, 16'h0);

    // redirect and stall together with a full queue
    repeat (6) step(1, 1, 1, 0, 16'h0);
    step(1, 1, 1, 1, 16'h0100);
    @(negedge clock); #1;
    check("rs_valid", {15'b0, ifid_valid}, 16'h0000);
    check("rs_next_addr", mem_if.imem_req_addr, 16'h0100);
    repeat (6) step(1, 1, 0, 0, 16'h0);

    // address wrap at the top of memory
    step(1, 1, 0, 1, 16'hFFFC);
    repeat (8) step(1, 1, 0, 0, 16'h0);

    // randomized traffic with an occasional mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 4,
           16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
